// File: rtl/div_unit_pkg.sv
// Shared constants and types for the execute-stage divider.
package div_unit_pkg;

  // ALU control codes from the decode stage
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;

  // One iteration per operand bit
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_code(input logic [7:0] code);
    return (code == EXE_DIV_OP) || (code == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration. Isolated so a higher-radix
// step can be swapped in without touching the controller.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Shift {rem, quo} left, try subtracting the divisor, restore if negative
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for the execute stage.
// Stalls the pipeline while iterating and pulses div_ready with
// {remainder, quotient} for the HI/LO write.
//
// state    | meaning
// ---------+------------------------------------------------
// DIV_IDLE | waiting; only state that can accept a start
// DIV_BUSY | one restoring iteration per cycle, WIDTH cycles
// DIV_DONE | signs applied, result presented, back to IDLE
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         alucontrolE,
  input  logic [WIDTH-1:0]   srcaE,
  input  logic [WIDTH-1:0]   srcbE,
  input  logic               flushE,
  output logic               div_stall,
  output logic               div_ready,
  output logic [2*WIDTH-1:0] div_result
);

  localparam int CW = $clog2(WIDTH);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q, a_raw_q;
  logic               neg_q_q, neg_r_q, b_zero_q;
  logic [2*WIDTH-1:0] result_q;

  logic               start;
  logic               signed_op;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] result_fix;

  assign signed_op = (alucontrolE == EXE_DIV_OP);
  assign start     = (state_q == DIV_IDLE) && !flushE && is_div_code(alucontrolE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush annuls a division in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = DIV_BUSY;
      DIV_BUSY: begin
        if (flushE)                           state_d = DIV_IDLE;
        else if (cnt_q == CW'(WIDTH - 1))     state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Sign fix-up and divide-by-zero override, evaluated while in DONE
  always_comb begin
    quo_fix = neg_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
    rem_fix = neg_r_q ? (~rem_q + WIDTH'(1)) : rem_q;
    if (b_zero_q) result_fix = {a_raw_q, {WIDTH{1'b1}}};
    else          result_fix = {rem_fix, quo_fix};
  end

  // Outputs: stall is combinational so the start cycle itself holds the pipe
  always_comb begin
    div_stall  = 1'b0;
    div_ready  = 1'b0;
    div_result = result_q;
    if (!flushE) begin
      div_stall = start || (state_q == DIV_BUSY);
      if (state_q == DIV_DONE) begin
        div_ready  = 1'b1;
        div_result = result_fix;
      end
    end
  end

  // Datapath: latch operands on start, iterate in BUSY, retain result after DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_raw_q  <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      b_zero_q <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            quo_q    <= (signed_op && srcaE[WIDTH-1]) ? (~srcaE + WIDTH'(1)) : srcaE;
            dvs_q    <= (signed_op && srcbE[WIDTH-1]) ? (~srcbE + WIDTH'(1)) : srcbE;
            a_raw_q  <= srcaE;
            neg_q_q  <= signed_op && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            neg_r_q  <= signed_op && srcaE[WIDTH-1];
            b_zero_q <= (srcbE == '0);
            rem_q    <= '0;
            cnt_q    <= '0;
          end
        end
        DIV_BUSY: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + CW'(1);
        end
        DIV_DONE: begin
          if (!flushE) result_q <= result_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus flush, reset,
// back-to-back and idle-code sequences.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [7:0]     alucontrolE;
  logic [W-1:0]   srcaE, srcbE;
  logic           flushE;
  logic           div_stall, div_ready;
  logic [2*W-1:0] div_result;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [2*W-1:0] last_exp;

  div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .alucontrolE (alucontrolE),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .flushE      (flushE),
    .div_stall   (div_stall),
    .div_ready   (div_ready),
    .div_result  (div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [7:0]     code;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Move to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Watch n cycles (sampled at negedge) counting ready pulses and stall cycles
  task automatic watch(input int n, output int rdy, output int stl);
    rdy = 0;
    stl = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (div_ready) rdy++;
      if (div_stall) stl++;
      if (i != n - 1) next_cycle();
    end
  endtask

  // Issue a division at T0 (DUT assumed idle) and check through T33.
  // Returns at T34 with the DIV code still on alucontrolE.
  task automatic run_div(input string name, input logic [7:0] code,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp);
    int bad;
    alucontrolE = code;
    srcaE       = a;
    srcbE       = b;
    @(negedge clk);
    chk({name, "_t0_stall"}, {63'd0, div_stall}, 64'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      next_cycle();
      if (k == 1) begin
        srcaE = $urandom;
        srcbE = $urandom;
      end
      @(negedge clk);
      if (div_stall !== 1'b1 || div_ready !== 1'b0) bad++;
    end
    chk({name, "_busy_window"}, 64'(bad), 64'd0);
    next_cycle();
    @(negedge clk);
    chk({name, "_t33_stall_ready"}, {62'd0, div_stall, div_ready}, 64'd1);
    chk({name, "_result"}, div_result, exp);
    last_exp = exp;
    next_cycle();
  endtask

  initial begin
    int rdy, stl;

    vecs[0]  = '{"divu_100_7",     EXE_DIVU_OP, 32'd100,      32'd7,        {32'd2,        32'd14}};
    vecs[1]  = '{"div_m7_2",       EXE_DIV_OP,  32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2]  = '{"div_7_m2",       EXE_DIV_OP,  32'd7,        32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD}};
    vecs[3]  = '{"div_ovf",        EXE_DIV_OP,  32'h80000000, 32'hFFFFFFFF, {32'd0,        32'h80000000}};
    vecs[4]  = '{"divu_by0",       EXE_DIVU_OP, 32'h12345678, 32'd0,        {32'h12345678, 32'hFFFFFFFF}};
    vecs[5]  = '{"div_m8_by0",     EXE_DIV_OP,  32'hFFFFFFF8, 32'd0,        {32'hFFFFFFF8, 32'hFFFFFFFF}};
    vecs[6]  = '{"divu_max_1",     EXE_DIVU_OP, 32'hFFFFFFFF, 32'd1,        {32'd0,        32'hFFFFFFFF}};
    vecs[7]  = '{"divu_max_16",    EXE_DIVU_OP, 32'hFFFFFFFF, 32'h10,       {32'hF,        32'h0FFFFFFF}};
    vecs[8]  = '{"div_m100_m7",    EXE_DIV_OP,  32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}};
    vecs[9]  = '{"divu_5_9",       EXE_DIVU_OP, 32'd5,        32'd9,        {32'd5,        32'd0}};
    vecs[10] = '{"divu_8000_ffff", EXE_DIVU_OP, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}};
    vecs[11] = '{"div_7fff_16",    EXE_DIV_OP,  32'h7FFFFFFF, 32'h10,       {32'hF,        32'h07FFFFFF}};

    rst         = 1'b1;
    alucontrolE = EXE_ADD_OP;
    srcaE       = '0;
    srcbE       = '0;
    flushE      = 1'b0;
    last_exp    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {div_result[61:0], div_stall, div_ready}, 64'd0);
    chk("reset_result", div_result, 64'd0);
    next_cycle();

    // Table-driven vectors, each followed by one idle cycle
    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].name, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp);
      alucontrolE = EXE_ADD_OP;
      @(negedge clk);
      chk({vecs[i].name, "_t34_idle"}, {62'd0, div_stall, div_ready}, 64'd0);
      chk({vecs[i].name, "_hold"}, div_result, vecs[i].exp);
      next_cycle();
    end

    // Flush at T10: annulled, no ready, result kept
    alucontrolE = EXE_DIVU_OP;
    srcaE = 32'd100;
    srcbE = 32'd7;
    for (int k = 1; k <= 10; k++) next_cycle();
    flushE = 1'b1;
    @(negedge clk);
    chk("flush_t10_stall", {63'd0, div_stall}, 64'd0);
    next_cycle();
    flushE = 1'b0;
    alucontrolE = EXE_ADD_OP;
    @(negedge clk);
    chk("flush_t11_stall", {63'd0, div_stall}, 64'd0);
    next_cycle();
    watch(40, rdy, stl);
    chk("flush_no_ready", 64'(rdy), 64'd0);
    chk("flush_result_kept", div_result, last_exp);
    next_cycle();

    // Back-to-back: second DIVU starts at T34, ready at T67
    run_div("b2b_first", EXE_DIVU_OP, 32'd100, 32'd7, {32'd2, 32'd14});
    run_div("b2b_second", EXE_DIVU_OP, 32'd9, 32'd3, {32'd0, 32'd3});
    alucontrolE = EXE_ADD_OP;
    @(negedge clk);
    chk("b2b_idle", {62'd0, div_stall, div_ready}, 64'd0);
    next_cycle();

    // Flush while idle blocks a start
    alucontrolE = EXE_DIV_OP;
    srcaE = 32'd50;
    srcbE = 32'd5;
    flushE = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", {63'd0, div_stall}, 64'd0);
    next_cycle();
    flushE = 1'b0;
    alucontrolE = EXE_ADD_OP;
    watch(40, rdy, stl);
    chk("idle_flush_no_start", 64'(rdy + stl), 64'd0);
    next_cycle();

    // Non-divide codes never stall
    stl = 0;
    for (int c = 0; c < 256; c += 7) begin
      logic [7:0] cc;
      cc = 8'(c);
      if (cc == EXE_DIV_OP || cc == EXE_DIVU_OP) cc = EXE_ADD_OP;
      alucontrolE = cc;
      @(negedge clk);
      if (div_stall || div_ready) stl++;
      next_cycle();
    end
    chk("non_div_codes", 64'(stl), 64'd0);

    // Reset at T5 of a division clears everything
    alucontrolE = EXE_DIVU_OP;
    srcaE = 32'd100;
    srcbE = 32'd7;
    next_cycle();
    alucontrolE = EXE_ADD_OP;
    for (int k = 2; k <= 5; k++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {62'd0, div_stall, div_ready}, 64'd0);
    chk("rst_mid_result", div_result, 64'd0);
    next_cycle();
    watch(40, rdy, stl);
    chk("rst_mid_quiet", 64'(rdy + stl), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider in the execute stage. It consumes the 8-bit `alucontrol` code from the decode stage. When the E-stage code is `EXE_DIV_OP` or `EXE_DIVU_OP`, it stalls the pipeline, runs a 32-iteration radix-2 restoring division and returns `{remainder, quotient}` for the HI/LO write. All other codes leave it idle and transparent.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; iteration count equals `WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alucontrolE` in 8: E-stage ALU control code.
- `srcaE` in WIDTH: dividend (rs).
- `srcbE` in WIDTH: divisor (rt).
- `flushE` in 1: E-stage flush (exception/eret); annuls any division in progress.
- `div_stall` out 1: hold the pipeline; combinational from state and `alucontrolE`.
- `div_ready` out 1: one-cycle pulse; `div_result` is valid this cycle.
- `div_result` out 2*WIDTH: `[2W-1:W]` = remainder (HI), `[W-1:0]` = quotient (LO).

## Operation
- States:
  - IDLE: the only state that accepts a start.
  - BUSY: iterations in progress.
  - DONE: result presented.
- start = IDLE & ~flushE & (alucontrolE == `EXE_DIV_OP` | `EXE_DIVU_OP`).
- On start:
  - signed_op = (DIV).
  - Latch |a| and |b| when signed, raw values otherwise.
  - Latch neg_q = signed_op & (a[W-1]^b[W-1]) and neg_r = signed_op & a[W-1].
  - Latch b_zero = (b == 0).
  - Clear the remainder accumulator; counter = 0; go to BUSY.
- BUSY, each cycle:
  - Shift {rem, quo} left 1.
  - trial = rem − divisor (W+1 bits).
  - If non-negative: rem = trial[W-1:0] and quo LSB = 1; else quo LSB = 0.
  - counter++.
  - When counter == W−1, go to DONE.
- DONE: apply signs, then return to IDLE unconditionally.
  - quotient = neg_q ? −quo : quo.
  - remainder = neg_r ? −rem : rem.
  - The start check is never made from DONE, so an unchanged `alucontrolE` does not restart.
- Divide by zero completes with normal timing and forces `div_result = {srcaE latched raw, {W{1'b1}}}`, for both signed and unsigned. It raises no exception.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0, from abs-value wraparound. No special case.
- `flushE` in BUSY or DONE: go to IDLE next cycle, no `div_ready`, result discarded. `flushE` while IDLE blocks a start.
- `rst` at any time: IDLE next edge, counter 0. Reset values: `div_stall` 0, `div_ready` 0, `div_result` 0.
- `div_result` holds its last value until the next DONE.

## Timing
- T0: start cycle (IDLE, DIV code); `div_stall` = 1 combinationally; operands latched at the end of T0.
- T1..T32: BUSY; `div_stall` = 1.
- T33: DONE; `div_stall` = 0, `div_ready` = 1, `div_result` valid. The pipeline advances at the end of T33 and HI/LO capture `div_result` on that edge.
- Total stall 33 cycles; issue-to-result latency 33 cycles.
- T34: IDLE; a back-to-back DIV now present in E starts immediately.
- `div_stall` = (IDLE & start) | BUSY. It is never asserted in DONE or when `flushE` = 1.
- The pipeline must hold `alucontrolE`, `srcaE` and `srcbE` stable during T0 only; operands are registered after that.

## Structure
- `EXE_DIV_OP` and `EXE_DIVU_OP` come from `defines.vh`.
- Add to `defines.vh`: state encodings `DIV_IDLE`, `DIV_BUSY` and `DIV_DONE` (2-bit), and `DIV_CYCLES` = 32.
- Sub-module `div_step`: combinational single iteration. Takes {rem, quo, divisor} and returns {rem', quo'}. Kept separate so a radix-4 version can replace it later.
- The FSM, counter, sign fix-up and divide-by-zero override live in `div_unit`.

## Test plan
- DIVU 100 / 7 → `div_stall` high for 33 cycles; T33 `div_ready` = 1, result = {0x00000002, 0x0000000E}.
- DIV −7 / 2 (0xFFFFFFF9 / 0x00000002) → result {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 0x12345678 / 0 → {0x12345678, 0xFFFFFFFF}; timing unchanged.
- Start DIVU 100/7, assert `flushE` at T10 → T11 IDLE, `div_stall` 0; no `div_ready` pulse; `div_result` unchanged.
- Back-to-back: DIVU 100/7, then DIVU 9/3 in E at T34 → second `div_ready` at T67, result {0, 3}. No restart at T33.
- Assert `rst` at T5 of a division → IDLE, all outputs 0 next edge. Non-DIV codes (e.g. `EXE_ADD_OP`) never assert `div_stall`.
